// File: rtl/dwt_coef_rle.sv
// Deadzone quantiser and zero-run-length encoder for the dwt_2 coefficient stream.
// Stage 1 quantises each coefficient; stage 2 turns zero runs into run tokens via a one-entry hold.
module dwt_coef_rle #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHIFT   = 2,
  parameter int unsigned THRESH  = 8,
  parameter int unsigned RUN_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] din,
  input  logic             last_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] dout,
  output logic             is_run_o,
  output logic             last_o
);

  localparam int unsigned      MW        = WIDTH + 1;
  localparam logic [MW-1:0]    SAT_MAG   = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [MW-1:0]    THRESH_M  = MW'(THRESH);
  localparam logic [WIDTH-1:0] RUN_MAX_W = WIDTH'(RUN_MAX);

  // Quantiser datapath; magnitude carries one extra bit so the most negative input is exact.
  logic             neg;
  logic [MW-1:0]    din_x;
  logic [MW-1:0]    mag;
  logic [MW-1:0]    qmag_raw;
  logic [MW-1:0]    qmag;
  logic [WIDTH-1:0] q_c;

  always_comb begin
    neg      = din[WIDTH-1];
    din_x    = {din[WIDTH-1], din};
    mag      = neg ? (~din_x + MW'(1)) : din_x;
    qmag_raw = (mag < THRESH_M) ? '0 : (mag >> SHIFT);
    qmag     = (qmag_raw > SAT_MAG) ? SAT_MAG : qmag_raw;
    q_c      = neg ? WIDTH'(~qmag + MW'(1)) : WIDTH'(qmag);
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_q;
  logic             s1_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= valid_i;
      s1_q     <= valid_i ? q_c : s1_q;
      s1_last  <= valid_i & last_i;
    end
  end

  // Stage-2 state: run counter, one pending token, registered output token.
  logic [WIDTH-1:0] run,       run_n;
  logic             hold_v,    hold_v_n;
  logic             hold_run,  hold_run_n;
  logic [WIDTH-1:0] hold_val,  hold_val_n;
  logic             hold_last, hold_last_n;
  logic             valid_n;
  logic [WIDTH-1:0] dout_n;
  logic             is_run_n;
  logic             last_n;
  logic [WIDTH-1:0] run_inc;
  logic             q_zero;

  always_comb begin
    valid_n     = 1'b0;
    dout_n      = dout;
    is_run_n    = 1'b0;
    last_n      = 1'b0;
    run_n       = run;
    hold_v_n    = hold_v;
    hold_run_n  = hold_run;
    hold_val_n  = hold_val;
    hold_last_n = hold_last;
    run_inc     = run + WIDTH'(1);
    q_zero      = (s1_q == '0);

    if (hold_v) begin
      // Pending token goes out first; the new item is absorbed behind it (run is always 0 here).
      valid_n  = 1'b1;
      dout_n   = hold_val;
      is_run_n = hold_run;
      last_n   = hold_last;
      hold_v_n = 1'b0;
      if (s1_valid) begin
        if (q_zero && !s1_last) begin
          run_n = run_inc;
        end else if (q_zero) begin
          hold_v_n    = 1'b1;
          hold_run_n  = 1'b1;
          hold_val_n  = run_inc;
          hold_last_n = 1'b1;
          run_n       = '0;
        end else begin
          hold_v_n    = 1'b1;
          hold_run_n  = 1'b0;
          hold_val_n  = s1_q;
          hold_last_n = s1_last;
        end
      end
    end else if (s1_valid) begin
      if (q_zero && !s1_last) begin
        if (run_inc == RUN_MAX_W) begin
          valid_n  = 1'b1;
          dout_n   = RUN_MAX_W;
          is_run_n = 1'b1;
          run_n    = '0;
        end else begin
          run_n = run_inc;
        end
      end else if (q_zero) begin
        valid_n  = 1'b1;
        dout_n   = run_inc;
        is_run_n = 1'b1;
        last_n   = 1'b1;
        run_n    = '0;
      end else if (run == '0) begin
        valid_n = 1'b1;
        dout_n  = s1_q;
        last_n  = s1_last;
      end else begin
        valid_n     = 1'b1;
        dout_n      = run;
        is_run_n    = 1'b1;
        run_n       = '0;
        hold_v_n    = 1'b1;
        hold_run_n  = 1'b0;
        hold_val_n  = s1_q;
        hold_last_n = s1_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run       <= '0;
      hold_v    <= 1'b0;
      hold_run  <= 1'b0;
      hold_val  <= '0;
      hold_last <= 1'b0;
      valid_o   <= 1'b0;
      dout      <= '0;
      is_run_o  <= 1'b0;
      last_o    <= 1'b0;
    end else begin
      run       <= run_n;
      hold_v    <= hold_v_n;
      hold_run  <= hold_run_n;
      hold_val  <= hold_val_n;
      hold_last <= hold_last_n;
      valid_o   <= valid_n;
      dout      <= dout_n;
      is_run_o  <= is_run_n;
      last_o    <= last_n;
    end
  end

endmodule

// File: tb/tb_dwt_coef_rle.sv
// Directed scoreboard bench for dwt_coef_rle: expected tokens are queued as stimulus is driven.
module tb_dwt_coef_rle;

  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic             is_run;
    logic [WIDTH-1:0] val;
    logic             last;
  } tok_t;

  logic             clk;
  logic             rst;
  logic             valid_i;
  logic [WIDTH-1:0] din;
  logic             last_i;
  logic             valid_o;
  logic [WIDTH-1:0] dout;
  logic             is_run_o;
  logic             last_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   tok_idx  = 0;
  tok_t sb[$];

  dwt_coef_rle #(.WIDTH(WIDTH), .SHIFT(2), .THRESH(8), .RUN_MAX(255)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .din      (din),
    .last_i   (last_i),
    .valid_o  (valid_o),
    .dout     (dout),
    .is_run_o (is_run_o),
    .last_o   (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic r, input int v, input logic l);
    tok_t t;
    t.is_run = r;
    t.val    = WIDTH'(v);
    t.last   = l;
    sb.push_back(t);
  endtask

  task automatic cyc(input logic v, input int d, input logic l);
    @(negedge clk);
    valid_i = v;
    din     = WIDTH'(d);
    last_i  = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
  endtask

  // Output monitor: every token must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o) begin
        chk($sformatf("tok%0d_expected", tok_idx), 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          tok_t got;
          tok_t exp;
          got = {is_run_o, dout, last_o};
          exp = sb.pop_front();
          chk($sformatf("tok%0d", tok_idx), 32'(got), 32'(exp));
        end
        tok_idx++;
      end else begin
        chk("idle_flags", 32'({is_run_o, last_o}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish within bound");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    valid_i = 1'b0;
    din     = '0;
    last_i  = 1'b0;

    // Held in reset with input toggling: outputs stay cleared.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid_i = ~valid_i;
      din     = WIDTH'(100);
      chk("rst_hold", 32'({valid_o, dout, is_run_o, last_o}), 32'd0);
    end
    @(negedge clk);
    valid_i = 1'b0;
    rst     = 1'b1;
    idle(2);

    // Quantise and two-cycle latency.
    push(1'b0, 25, 1'b0);
    push(1'b0, -25, 1'b0);
    push(1'b1, 2, 1'b0);
    push(1'b0, -8192, 1'b0);
    cyc(1'b1, 100, 1'b0);
    cyc(1'b1, -100, 1'b0);
    chk("lat_early", 32'(valid_o), 32'd0);
    cyc(1'b1, 7, 1'b0);
    chk("lat_first", 32'({valid_o, dout}), 32'({1'b1, 16'd25}));
    cyc(1'b1, -7, 1'b0);
    cyc(1'b1, -32768, 1'b0);

    // Run then value, value held behind the run token.
    push(1'b1, 3, 1'b0);
    push(1'b0, 10, 1'b1);
    cyc(1'b1, 0, 1'b0);
    cyc(1'b1, 0, 1'b0);
    cyc(1'b1, 0, 1'b0);
    cyc(1'b1, 40, 1'b1);

    // Trailing zeros close the frame with a last run token.
    push(1'b0, 3, 1'b0);
    push(1'b1, 3, 1'b1);
    cyc(1'b1, 12, 1'b0);
    cyc(1'b1, 0, 1'b0);
    cyc(1'b1, 0, 1'b0);
    cyc(1'b1, 0, 1'b1);

    // RUN_MAX splitting, with idle gaps inside the run.
    push(1'b1, 255, 1'b0);
    push(1'b1, 255, 1'b0);
    push(1'b1, 90, 1'b0);
    push(1'b0, 4, 1'b1);
    for (int i = 0; i < 600; i++) begin
      cyc(1'b1, 0, 1'b0);
      if (i % 150 == 149) cyc(1'b0, 0, 1'b0);
    end
    cyc(1'b1, 16, 1'b1);

    // Alternating zero/nonzero back-to-back, then a zero last while a value is held.
    push(1'b1, 1, 1'b0);
    push(1'b0, 5, 1'b0);
    push(1'b1, 1, 1'b0);
    push(1'b0, 5, 1'b0);
    push(1'b0, 5, 1'b0);
    push(1'b1, 1, 1'b1);
    cyc(1'b1, 0, 1'b0);
    cyc(1'b1, 20, 1'b0);
    cyc(1'b1, 0, 1'b0);
    cyc(1'b1, 20, 1'b0);
    cyc(1'b1, 20, 1'b0);
    cyc(1'b1, 0, 1'b1);
    idle(4);

    // Reset while a value sits in the hold register: it must never appear.
    push(1'b1, 1, 1'b0);
    cyc(1'b1, 0, 1'b0);
    cyc(1'b1, 20, 1'b0);
    cyc(1'b0, 0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async", 32'({valid_o, dout, is_run_o, last_o}), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(5);
    chk("post_rst_quiet", 32'(valid_o), 32'd0);

    // First token after release belongs to the new stream.
    push(1'b0, 12, 1'b1);
    cyc(1'b1, 50, 1'b1);
    cyc(1'b0, 0, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    idle(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dwt_coef_rle.md
Name: dwt_coef_rle

Overview:
- Downstream consumer of the dwt_2 coefficient stream.
- Applies deadzone quantisation to each signed coefficient, then run-length encodes zero coefficients into run tokens.
- Emits a token stream (value tokens and run tokens) for the entropy/packing stage.
- Valid-only streaming, no backpressure, same as dwt_2: accepts one coefficient per cycle at most.

Parameters:
- WIDTH, 16: coefficient and token width in bits (matches dwt_2).
- SHIFT, 2: quantiser right-shift applied to the magnitude.
- THRESH, 8: deadzone; a magnitude below THRESH quantises to 0.
- RUN_MAX, 255: maximum zero count per run token. Must satisfy 2 ≤ RUN_MAX ≤ 2^(WIDTH-1)-1.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous reset, active-low (0 = reset).
- valid_i, input, 1: din/last_i valid this cycle.
- din, input, WIDTH: signed coefficient from dwt_2 dout.
- last_i, input, 1: din is the final coefficient of the frame.
- valid_o, output, 1: token valid this cycle.
- dout, output, WIDTH: token payload. Signed quantised value, or unsigned run length.
- is_run_o, output, 1: 1 = dout is a zero-run length; 0 = dout is a quantised value.
- last_o, output, 1: final token of the frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - valid_o=0, dout=0, is_run_o=0, last_o=0.
  - Run counter=0, hold register empty, stage-1 valid=0.
  - Any partial frame is discarded.
- Stage 1, quantise (registered, one cycle):
  - mag = |din| computed in WIDTH+1 bits, so -2^(WIDTH-1) is handled.
  - q = 0 if mag < THRESH, else mag >> SHIFT; sign of din is reapplied.
  - Result is a signed WIDTH value. It cannot overflow for SHIFT ≥ 1. For SHIFT=0, saturate to ±(2^(WIDTH-1)-1).
  - valid and last are carried alongside q.
- Stage 2, RLE (registered outputs). Cases per stage-1 valid item:
  - q=0, not last: run += 1. If run reaches RUN_MAX, emit run token RUN_MAX and set run=0. Otherwise no new token.
  - q=0, last: emit run token (run+1) with last_o=1; run=0.
  - q≠0, run=0: emit value token q (is_run_o=0), with last_o=last.
  - q≠0, run>0: emit run token run (last_o=0); q and last go to the hold register; run=0.
- Hold register (one entry):
  - An occupied hold is emitted with priority in the next output cycle.
  - If a new item also arrives that cycle, the new item is processed against the run counter in the same cycle, with these outcomes:
    - zero item: counted only.
    - nonzero item with run=0: goes into the hold register, replacing the emitted entry.
    - nonzero item with run>0: cannot occur.
  - One entry is provably sufficient. A run>0 requires a preceding zero cycle, which drains the hold. RUN_MAX ≥ 2 ensures a max-run emission never coincides with an occupied hold.
- Latency: a value token with no pending run appears 2 cycles after valid_i. A held value appears 3 cycles after valid_i.
- valid_o is a one-cycle pulse per token. Outputs hold their last value when valid_o=0; last_o and is_run_o are 0 when valid_o=0.
- Idle gaps (valid_i=0) do not affect the run count. Runs span gaps until a nonzero value, last_i, or RUN_MAX.
- Frames are back-to-back capable: a new frame may start the cycle after last_i. A held last token drains before the new frame's first token, because new tokens queue behind the hold.
- Reset asserted mid-frame clears all state immediately. The first output after release belongs to the new stream.

Test Plan:
- Reset: rst=0 with valid_i toggling -> valid_o=0, dout=0, is_run_o=0, last_o=0 throughout. Release rst -> first token 2 cycles after first valid_i.
- Quantise: din = 100, -100, 7, -7, -32768 (SHIFT=2, THRESH=8) -> 7 is treated as zero, so tokens are value 25, value -25, then run 2, then value -8192 with is_run_o=1 on the run token only.
- Run then value: din 0,0,0,40 with last_i on 40 -> run token 3 (last_o=0), next cycle value 10 (last_o=1).
- Trailing zeros: din 12,0,0,0 with last_i on the final 0 -> value 3, then run 3 with last_o=1.
- RUN_MAX: 600 consecutive zeros, then 16 with last_i -> run 255, run 255, run 90, value 4 (last_o=1).
- Alternating and reset: 0,20,0,20,20 continuous -> run1, 5, run1, 5, 5 in order with no lost tokens. rst=0 asserted mid-stream with a pending hold -> outputs clear immediately and nothing is emitted after release until new input.
